// File: rtl/td4_pkg.sv
// Shared definitions for the TD4 program loader and the TD4 CPU core.
// Holds the loader state encoding, the instruction fed to the core while
// no program is running, and the TD4 opcode values the core decodes.
package td4_pkg;

    // Loader state encoding. This value is also driven out on the 2-bit
    // state port, so the numeric values are part of the interface.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_RUN  = 2'b10
    } state_t;

    // ADD A,0 does nothing useful. The core sees it whenever it is held in reset.
    localparam logic [3:0] NOP_OPCODE = 4'b0000;

    // TD4 opcodes shared with the CPU core.
    localparam logic [3:0] OP_ADD_A   = 4'b0000;
    localparam logic [3:0] OP_ADD_B   = 4'b1010;
    localparam logic [3:0] OP_MOV_A_I = 4'b1100;
    localparam logic [3:0] OP_MOV_B_I = 4'b1110;
    localparam logic [3:0] OP_MOV_A_B = 4'b1000;
    localparam logic [3:0] OP_MOV_B_A = 4'b0010;

    // Instruction memory geometry. The 4-bit PC fixes these values.
    localparam int IMEM_DEPTH = 16;
    localparam int IMEM_WIDTH = 8;

endpackage

// File: rtl/td4_imem.sv
// 16 x 8 instruction register file for the TD4 program loader.
// Ports:
//   clk, rst      - clock and asynchronous active-high reset (clears all words)
//   we            - write enable
//   waddr, wdata  - write port, which updates memory on the rising edge
//   raddr, rdata  - purely combinational read port
module td4_imem
    import td4_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [3:0]            waddr,
    input  logic [IMEM_WIDTH-1:0] wdata,
    input  logic [3:0]            raddr,
    output logic [IMEM_WIDTH-1:0] rdata
);

    logic [IMEM_WIDTH-1:0] mem [IMEM_DEPTH];

    // Reset clears every word so that a freshly reset core sees ADD A,0
    // everywhere. A LOAD does not clear memory, so words that were not
    // rewritten keep their previous contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < IMEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // The read has no latency, so a PC change reaches the core in the same cycle.
    assign rdata = mem[raddr];

endmodule

// File: rtl/td4_prog_loader.sv
// Program store and loader placed directly upstream of the TD4 CPU core.
// A nibble handshake fills the program, sending the high nibble of each
// word first. In RUN the core fetches from it by pc. Outside RUN the core
// is held in reset and sees ADD A,0.
// Ports:
//   clk, rst                  - clock and asynchronous active-high reset
//   load_start, run, load_end - mode control
//   ld_valid, ld_ready        - nibble handshake
//   ld_nibble                 - nibble data
//   pc                        - program counter from the core
//   opcode, immediate         - instruction fields to the core
//   cpu_rst_n                 - active-low core reset, high only in RUN
//   state, words_loaded       - status outputs
module td4_prog_loader
    import td4_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load_start,
    input  logic       run,
    input  logic       ld_valid,
    output logic       ld_ready,
    input  logic [3:0] ld_nibble,
    input  logic       load_end,
    input  logic [3:0] pc,
    output logic [3:0] opcode,
    output logic [3:0] immediate,
    output logic       cpu_rst_n,
    output logic [1:0] state,
    output logic [4:0] words_loaded
);

    state_t     state_q;
    state_t     next_state;
    logic [3:0] addr_q;
    logic       phase_q;
    logic [3:0] hold_q;
    logic [4:0] count_q;

    logic       restart;
    logic       xfer_hi;
    logic       xfer_lo;
    logic [7:0] rdata;

    // Next-state logic and the strobes that drive the nibble assembler.
    // When load_start is seen in LOAD, it restarts the load and drops any
    // transfer in the same cycle. When load_end arrives together with a
    // transfer, the transfer is still processed.
    always_comb begin
        next_state = state_q;
        restart    = 1'b0;
        xfer_hi    = 1'b0;
        xfer_lo    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    next_state = ST_LOAD;
                    restart    = 1'b1;
                end else if (run) begin
                    next_state = ST_RUN;
                end
            end
            ST_LOAD: begin
                if (load_start) begin
                    restart = 1'b1;
                end else begin
                    if (ld_valid) begin
                        if (!phase_q) begin
                            xfer_hi = 1'b1;
                        end else begin
                            xfer_lo = 1'b1;
                            if (addr_q == 4'd15) begin
                                next_state = ST_RUN;
                            end
                        end
                    end
                    if (load_end) begin
                        next_state = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (load_start) begin
                    next_state = ST_LOAD;
                    restart    = 1'b1;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= next_state;
        end
    end

    // Nibble assembler and word counter. When LOAD is left, the phase is
    // cleared, which discards any pending half word. The word count stays
    // at its final value through RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            phase_q <= 1'b0;
            hold_q  <= '0;
            count_q <= '0;
        end else if (restart) begin
            addr_q  <= '0;
            phase_q <= 1'b0;
            count_q <= '0;
        end else begin
            if (xfer_hi) begin
                hold_q  <= ld_nibble;
                phase_q <= 1'b1;
            end else if (xfer_lo) begin
                addr_q  <= addr_q + 4'd1;
                phase_q <= 1'b0;
                if (count_q != 5'd16) begin
                    count_q <= count_q + 5'd1;
                end
            end
            if (next_state != ST_LOAD) begin
                phase_q <= 1'b0;
            end
        end
    end

    td4_imem u_imem (
        .clk   (clk),
        .rst   (rst),
        .we    (xfer_lo),
        .waddr (addr_q),
        .wdata ({hold_q, ld_nibble}),
        .raddr (pc),
        .rdata (rdata)
    );

    // Status and core-control outputs come only from the state register,
    // so they cannot glitch. ld_ready never depends on ld_valid.
    assign ld_ready     = (state_q == ST_LOAD);
    assign cpu_rst_n    = (state_q == ST_RUN);
    assign state        = state_q;
    assign words_loaded = count_q;
    assign opcode       = (state_q == ST_RUN) ? rdata[7:4] : NOP_OPCODE;
    assign immediate    = (state_q == ST_RUN) ? rdata[3:0] : 4'b0000;

endmodule

// File: tb/tb_td4_prog_loader.sv
// Self-checking bench for td4_prog_loader. A word-level reference model
// (ref_mem, ref_count) is updated whenever the bench finishes sending a
// whole word. Outputs are sampled 1 time unit after each rising edge.
module tb_td4_prog_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_start;
    logic       run;
    logic       ld_valid;
    logic       ld_ready;
    logic [3:0] ld_nibble;
    logic       load_end;
    logic [3:0] pc;
    logic [3:0] opcode;
    logic [3:0] immediate;
    logic       cpu_rst_n;
    logic [1:0] state;
    logic [4:0] words_loaded;

    int checks = 0;
    int errors = 0;

    logic [7:0] ref_mem [16];
    int         ref_count;
    logic [7:0] prog [16];

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_LOAD = 2'b01;
    localparam logic [1:0] S_RUN  = 2'b10;

    td4_prog_loader dut (
        .clk          (clk),
        .rst          (rst),
        .load_start   (load_start),
        .run          (run),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_nibble    (ld_nibble),
        .load_end     (load_end),
        .pc           (pc),
        .opcode       (opcode),
        .immediate    (immediate),
        .cpu_rst_n    (cpu_rst_n),
        .state        (state),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic ls, input logic rn, input logic le);
        load_start = ls;
        run        = rn;
        load_end   = le;
    endtask

    task automatic start_load();
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        ref_count = 0;
        checkOutput("start_state", 32'(state), 32'(S_LOAD));
        checkOutput("start_ready", 32'(ld_ready), 32'd1);
        checkOutput("start_count", 32'(words_loaded), 32'd0);
    endtask

    // Sends the first n words of w starting at address 0.
    // Mode 0 sends back-to-back, mode 1 alternates valid/idle,
    // and mode 2 inserts random stalls.
    task automatic load_words(input logic [7:0] w [16], input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            for (int h = 0; h < 2; h++) begin
                if (mode == 2) begin
                    int s;
                    s = $urandom_range(2);
                    repeat (s) begin
                        ld_valid = 1'b0;
                        tick();
                    end
                end
                ld_valid  = 1'b1;
                ld_nibble = (h == 0) ? w[i][7:4] : w[i][3:0];
                tick();
                ld_valid = 1'b0;
                if (h == 1) begin
                    ref_mem[i] = w[i];
                    ref_count  = i + 1;
                end
                checkOutput("xfer_state", 32'(state),
                            32'((i == 15 && h == 1) ? S_RUN : S_LOAD));
                if (mode == 1) begin
                    tick();
                end
            end
        end
    endtask

    task automatic end_load();
        applyStimulus(1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    // Checks every fetched instruction and the status outputs in RUN.
    task automatic sweep(input string tag);
        checkOutput({tag, "_state"}, 32'(state), 32'(S_RUN));
        checkOutput({tag, "_cpurst"}, 32'(cpu_rst_n), 32'd1);
        checkOutput({tag, "_count"}, 32'(words_loaded), 32'(ref_count));
        for (int p = 0; p < 16; p++) begin
            pc = 4'(p);
            #1;
            checkOutput({tag, "_fetch"}, {24'd0, opcode, immediate}, {24'd0, ref_mem[p]});
        end
    endtask

    initial begin
        rst       = 1'b1;
        ld_valid  = 1'b0;
        ld_nibble = 4'h0;
        pc        = 4'h0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
        ref_count = 0;
        repeat (2) tick();
        rst = 1'b0;

        // Idle after reset: the core is held in reset and sees NOP.
        pc = 4'h5;
        tick();
        checkOutput("idle_state", 32'(state), 32'(S_IDLE));
        checkOutput("idle_ready", 32'(ld_ready), 32'd0);
        checkOutput("idle_cpurst", 32'(cpu_rst_n), 32'd0);
        checkOutput("idle_fetch", {24'd0, opcode, immediate}, 32'd0);

        // Run the reset-cleared memory.
        applyStimulus(1'b0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        sweep("blank");

        // Full load, back-to-back.
        start_load();
        prog[0] = 8'hC3;
        prog[1] = 8'hE5;
        for (int i = 2; i < 16; i++) prog[i] = 8'h00;
        load_words(prog, 16, 0);
        pc = 4'd0; #1;
        checkOutput("full_op0", 32'(opcode), 32'hC);
        checkOutput("full_im0", 32'(immediate), 32'h3);
        pc = 4'd1; #1;
        checkOutput("full_op1", 32'(opcode), 32'hE);
        checkOutput("full_im1", 32'(immediate), 32'h5);
        sweep("full");

        // Reload from RUN, then alternate valid on/off.
        pc = 4'd0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        ref_count = 0;
        checkOutput("reload_cpurst", 32'(cpu_rst_n), 32'd0);
        checkOutput("reload_fetch", {24'd0, opcode, immediate}, 32'd0);
        checkOutput("reload_count", 32'(words_loaded), 32'd0);
        checkOutput("reload_state", 32'(state), 32'(S_LOAD));
        load_words(prog, 16, 1);
        sweep("stall");

        // Random full load with random stalls.
        start_load();
        for (int i = 0; i < 16; i++) prog[i] = 8'($urandom);
        load_words(prog, 16, 2);
        sweep("rand_full");

        // Early end with a pending half word.
        start_load();
        prog[0] = 8'hA1;
        prog[1] = 8'h23;
        load_words(prog, 2, 0);
        ld_valid  = 1'b1;
        ld_nibble = 4'hF;
        tick();
        ld_valid = 1'b0;
        end_load();
        sweep("early");

        // A restart in LOAD overrides a transfer and load_end in the same
        // cycle. The next word must land at address 0.
        start_load();
        ld_valid  = 1'b1;
        ld_nibble = 4'h7;
        tick();
        ld_nibble = 4'h9;
        applyStimulus(1'b1, 1'b0, 1'b1);
        tick();
        ld_valid = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        ref_count = 0;
        checkOutput("restart_state", 32'(state), 32'(S_LOAD));
        checkOutput("restart_count", 32'(words_loaded), 32'd0);
        prog[0] = 8'h5A;
        load_words(prog, 1, 0);
        end_load();
        sweep("restart");

        // Randomized sessions of random length and stall pattern.
        for (int s = 0; s < 4; s++) begin
            int n;
            int mode;
            n    = $urandom_range(16);
            mode = $urandom_range(2);
            start_load();
            for (int i = 0; i < 16; i++) prog[i] = 8'($urandom);
            load_words(prog, n, mode);
            if (n < 16) begin
                if ($urandom_range(1) == 1) begin
                    ld_valid  = 1'b1;
                    ld_nibble = 4'($urandom);
                    tick();
                    ld_valid = 1'b0;
                end
                end_load();
            end
            sweep("session");
        end

        // Asynchronous reset in the middle of a cycle during RUN.
        #3;
        rst = 1'b1;
        #1;
        checkOutput("arst_state", 32'(state), 32'(S_IDLE));
        checkOutput("arst_cpurst", 32'(cpu_rst_n), 32'd0);
        checkOutput("arst_ready", 32'(ld_ready), 32'd0);
        checkOutput("arst_fetch", {24'd0, opcode, immediate}, 32'd0);
        checkOutput("arst_count", 32'(words_loaded), 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
        ref_count = 0;

        // In IDLE, load_start wins over run. Then load_end arrives with the
        // completing nibble.
        applyStimulus(1'b1, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("prio_state", 32'(state), 32'(S_LOAD));
        ld_valid  = 1'b1;
        ld_nibble = 4'hB;
        tick();
        ld_nibble = 4'h4;
        applyStimulus(1'b0, 1'b0, 1'b1);
        tick();
        ld_valid = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        ref_mem[0] = 8'hB4;
        ref_count  = 1;
        sweep("prio_end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
